enemy_bullet_hit: RTL
=====================

ENEMY_BULLET_HIT -- requirements
Module: enemy_bullet_hit

Interface
REQ-001 The module SHALL have parameter NUM, default 8, meaning number of bullet slots (power of two, 2..16).
REQ-002 The module SHALL have parameter HIT_R, default 8, meaning hitbox half-width in pixels.
REQ-003 The module SHALL have port clk_22  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port gamestart  input  1  synchronous clear of the block.
REQ-006 The module SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 The module SHALL have ports reimu_x, reimu_y  input  10 each  player centre, unsigned pixels.
REQ-008 The module SHALL have port reimuE  input  1  player vulnerable; 0 means invincible or dead.
REQ-009 The module SHALL have port spawn_valid  input  1  spawn request.
REQ-010 The module SHALL have ports spawn_x, spawn_y  input  10 each  spawn position.
REQ-011 The module SHALL have ports spawn_dx, spawn_dy  input  4 each  signed two's-complement per-frame velocity.
REQ-012 The module SHALL have port spawn_ready  output  1  spawn accepted this cycle when high with spawn_valid.
REQ-013 The module SHALL have port shot  output  1  one-cycle hit pulse to the life counter.
REQ-014 The module SHALL have port active_count  output  5  number of live slots.
REQ-015 The module SHALL have port busy  output  1  high when the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN, REPORT; IDLE->SCAN on frame_tick, SCAN->REPORT after slot NUM-1, REPORT->IDLE unconditionally.
REQ-017 A frame_tick outside IDLE SHALL be ignored; a tick sampled at edge k SHALL put the FSM in SCAN for cycles k+1..k+NUM and REPORT at cycle k+NUM+1.
REQ-018 SCAN SHALL process exactly one slot per cycle, index 0 first, incrementing by one.
REQ-019 Processing an active slot SHALL add the sign-extended dx/dy to x/y in 11-bit signed arithmetic.
REQ-020 The slot SHALL be deactivated if the new x<0, x>639, y<0 or y>479; no hit test applies to it.
REQ-021 Otherwise the slot SHALL store the new position; it is a hit when |x-reimu_x|<HIT_R and |y-reimu_y|<HIT_R, with reimuE=1 sampled that cycle.
REQ-022 A hit SHALL deactivate the slot and set a per-frame hit flag; several hits in one frame SHALL still set one flag.
REQ-023 When reimuE=0 overlapping bullets SHALL stay active and keep moving.
REQ-024 Inactive slots SHALL be skipped, keeping cycle count fixed at NUM.
REQ-025 shot SHALL be high only during the REPORT cycle and only if the hit flag is set; the flag SHALL clear on leaving REPORT.
REQ-026 spawn_ready SHALL be high only in IDLE with at least one free slot, and combinationally independent of spawn_valid.
REQ-027 On spawn_valid&spawn_ready the lowest-index free slot SHALL load x, y, dx, dy and become active at the next edge.
REQ-028 A spawn and a frame_tick in the same IDLE cycle SHALL both be taken, and the new bullet SHALL be moved in that frame's scan.
REQ-029 active_count SHALL equal the live-slot count, registered, updated on the edge after any change.
REQ-030 gamestart SHALL clear all slots, the hit flag, shot and active_count, force IDLE, and take priority over frame_tick and spawn.

Reset
REQ-031 On rst all slots SHALL be inactive, the FSM SHALL be IDLE, shot=0, active_count=0, busy=0, spawn_ready=1.
REQ-032 rst asserted mid-SCAN SHALL abort the frame with no shot pulse.

Verification
REQ-033 Spawn (100,100,dx=+2,dy=0) with player at (200,200) and one tick -> slot0 x=102, shot stays 0, busy high for NUM+1 cycles.
REQ-034 Spawn at (195,200,dx=+3,dy=0), player at (200,200), reimuE=1, tick -> shot=1 exactly at cycle k+NUM+1, active_count goes 1->0.
REQ-035 Same as REQ-034 with reimuE=0 -> no shot, bullet remains, active_count=1.
REQ-036 Spawn at (638,10,dx=+3,dy=0) and one at (5,5,dx=-7,dy=0), tick -> both deactivated, active_count=0, no shot.
REQ-037 Fill all NUM slots -> spawn_ready=0; a frame_tick during SCAN is ignored; three overlapping bullets give a single one-cycle shot.
REQ-038 gamestart asserted mid-SCAN with a pending hit -> next cycle IDLE, active_count=0, no shot.

Source files
------------

// File: rtl/enemy_bullet_hit.sv
// Enemy bullet pool: per-frame sequential move, bounds cull and player hit test,
// one slot per cycle, with a single shot pulse reported at the end of each frame.
module enemy_bullet_hit #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned HIT_R = 8
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic       frame_tick,
    input  logic [9:0] reimu_x,
    input  logic [9:0] reimu_y,
    input  logic       reimuE,
    input  logic       spawn_valid,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  logic [3:0] spawn_dx,
    input  logic [3:0] spawn_dy,
    output logic       spawn_ready,
    output logic       shot,
    output logic [4:0] active_count,
    output logic       busy
);

    localparam int unsigned IDX_W = $clog2(NUM);
    localparam int unsigned POS_W = 10;
    localparam int unsigned VEL_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM-1:0]     valid_q, valid_d;
    logic [POS_W-1:0]   x_q [NUM];
    logic [POS_W-1:0]   x_d [NUM];
    logic [POS_W-1:0]   y_q [NUM];
    logic [POS_W-1:0]   y_d [NUM];
    logic [VEL_W-1:0]   dx_q [NUM];
    logic [VEL_W-1:0]   dx_d [NUM];
    logic [VEL_W-1:0]   dy_q [NUM];
    logic [VEL_W-1:0]   dy_d [NUM];
    logic               hit_q, hit_d;
    logic               shot_q, shot_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   free_idx;
    logic signed [10:0] nx, ny;
    logic signed [11:0] ddx, ddy;
    logic [11:0]        adx, ady;
    logic               oob, hit_now;

    // Next-state: IDLE accepts spawns/ticks, SCAN updates one slot per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        hit_d   = hit_q;
        shot_d  = 1'b0;
        hit_now = 1'b0;

        free_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end

        nx  = $signed({1'b0, x_q[idx_q]}) + $signed({{7{dx_q[idx_q][3]}}, dx_q[idx_q]});
        ny  = $signed({1'b0, y_q[idx_q]}) + $signed({{7{dy_q[idx_q][3]}}, dy_q[idx_q]});
        oob = (nx < 11'sd0) || (nx > 11'sd639) || (ny < 11'sd0) || (ny > 11'sd479);
        ddx = $signed({2'b00, nx[9:0]}) - $signed({2'b00, reimu_x});
        ddy = $signed({2'b00, ny[9:0]}) - $signed({2'b00, reimu_y});
        adx = ddx[11] ? 12'(-ddx) : 12'(ddx);
        ady = ddy[11] ? 12'(-ddy) : 12'(ddy);

        case (state_q)
            IDLE: begin
                if (spawn_valid && ready_q) begin
                    valid_d[free_idx] = 1'b1;
                    x_d[free_idx]     = spawn_x;
                    y_d[free_idx]     = spawn_y;
                    dx_d[free_idx]    = spawn_dx;
                    dy_d[free_idx]    = spawn_dy;
                end
                if (frame_tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (valid_q[idx_q]) begin
                    if (oob) begin
                        valid_d[idx_q] = 1'b0;
                    end else begin
                        x_d[idx_q] = nx[9:0];
                        y_d[idx_q] = ny[9:0];
                        hit_now = reimuE && (adx < 12'(HIT_R)) && (ady < 12'(HIT_R));
                        if (hit_now) valid_d[idx_q] = 1'b0;
                    end
                end
                hit_d = hit_q | hit_now;
                if (idx_q == IDX_W'(NUM - 1)) begin
                    state_d = REPORT;
                    shot_d  = hit_d;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            REPORT: begin
                state_d = IDLE;
                hit_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (gamestart) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = '0;
            hit_d   = 1'b0;
            shot_d  = 1'b0;
        end

        cnt_d = '0;
        for (int i = 0; i < NUM; i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && !(&valid_d);
    end

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= '0;
            hit_q   <= 1'b0;
            shot_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            for (int i = 0; i < NUM; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            shot_q  <= shot_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    assign spawn_ready  = ready_q;
    assign shot         = shot_q;
    assign active_count = cnt_q;
    assign busy         = busy_q;

endmodule
